// File: rtl/ptp_media_clock_sched.sv
// ptp_media_clock_sched: starts, runs, stops and re-synchronises a PTP-locked
// media-clock tick stream with frame grouping, lateness detection and resync.
module ptp_media_clock_sched #(
  parameter int unsigned BASE_PERIOD_NS = 20833,
  parameter int unsigned REM_NS         = 16000,
  parameter int unsigned REM_DEN        = 48000,
  parameter int unsigned FRAME_SAMPLES  = 48,
  parameter int unsigned LATE_LIMIT_NS  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] ptp_sec,
  input  logic [31:0] ptp_ns,
  input  logic        ptp_step,
  input  logic [47:0] cfg_start_sec,
  input  logic [31:0] cfg_start_ns,
  input  logic        cfg_arm,
  input  logic        cfg_stop,
  output logic        sample_tick,
  output logic        frame_tick,
  output logic [31:0] sample_cnt,
  output logic [1:0]  state,
  output logic        cfg_err,
  output logic [15:0] resync_cnt
);

  localparam int unsigned SEC_W  = 48;
  localparam int unsigned NS_W   = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned FIDX_W = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
  localparam logic [NS_W-1:0] NS_PER_SEC = NS_W'(1_000_000_000);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_RUN    = 2'd2,
    S_RESYNC = 2'd3
  } state_t;

  state_t              st;
  logic [SEC_W-1:0]    ptp_sec_q;
  logic [NS_W-1:0]     ptp_ns_q;
  logic                ptp_step_q;
  logic [SEC_W-1:0]    tgt_sec;
  logic [NS_W-1:0]     tgt_ns;
  logic [NS_W-1:0]     rem_acc;
  logic [FIDX_W-1:0]   frame_idx;

  logic                ge_c;
  logic                late_c;
  logic [NS_W:0]       late_ns_c;
  logic [NS_W-1:0]     rem_sum_c;
  logic [NS_W-1:0]     rem_nxt_c;
  logic [NS_W-1:0]     period_c;
  logic [SEC_W+NS_W-1:0] adv_c;
  logic [SEC_W+NS_W-1:0] resync_tgt_c;
  logic [FIDX_W-1:0]   frame_idx_nxt_c;
  logic                start_ok_c;

  // Add ns to a (sec, ns) time, carrying a wrap at one second into seconds
  function automatic logic [SEC_W+NS_W-1:0] add_ns(input logic [SEC_W-1:0] s,
                                                   input logic [NS_W-1:0]  n,
                                                   input logic [NS_W-1:0]  inc);
    logic [NS_W:0] sum;
    sum = {1'b0, n} + {1'b0, inc};
    if (sum >= {1'b0, NS_PER_SEC}) begin
      add_ns = {s + SEC_W'(1), NS_W'(sum - {1'b0, NS_PER_SEC})};
    end else begin
      add_ns = {s, sum[NS_W-1:0]};
    end
  endfunction

  assign state = st;

  // Target compare on registered PTP time
  assign ge_c = (ptp_sec_q > tgt_sec) || ((ptp_sec_q == tgt_sec) && (ptp_ns_q >= tgt_ns));

  assign start_ok_c = (cfg_start_ns < NS_PER_SEC);

  // Lateness of the current time past the target; more than one second apart counts as too late
  always_comb begin
    late_ns_c = '0;
    late_c    = 1'b1;
    if (ptp_sec_q == tgt_sec) begin
      late_ns_c = {1'b0, ptp_ns_q} - {1'b0, tgt_ns};
      late_c    = (late_ns_c > (NS_W+1)'(LATE_LIMIT_NS));
    end else if (ptp_sec_q == tgt_sec + SEC_W'(1)) begin
      late_ns_c = {1'b0, ptp_ns_q} + {1'b0, NS_PER_SEC} - {1'b0, tgt_ns};
      late_c    = (late_ns_c > (NS_W+1)'(LATE_LIMIT_NS));
    end
  end

  // Bresenham period selection and next target
  always_comb begin
    rem_sum_c = rem_acc + NS_W'(REM_NS);
    if (rem_sum_c >= NS_W'(REM_DEN)) begin
      rem_nxt_c = rem_sum_c - NS_W'(REM_DEN);
      period_c  = NS_W'(BASE_PERIOD_NS + 1);
    end else begin
      rem_nxt_c = rem_sum_c;
      period_c  = NS_W'(BASE_PERIOD_NS);
    end
    adv_c        = add_ns(tgt_sec, tgt_ns, period_c);
    resync_tgt_c = add_ns(ptp_sec_q, ptp_ns_q, NS_W'(BASE_PERIOD_NS));
  end

  // Frame position wraps after FRAME_SAMPLES samples
  assign frame_idx_nxt_c = (frame_idx == FIDX_W'(FRAME_SAMPLES - 1)) ? '0 : frame_idx + FIDX_W'(1);

  // Scheduler state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= S_IDLE;
      ptp_sec_q   <= '0;
      ptp_ns_q    <= '0;
      ptp_step_q  <= 1'b0;
      tgt_sec     <= '0;
      tgt_ns      <= '0;
      rem_acc     <= '0;
      frame_idx   <= '0;
      sample_tick <= 1'b0;
      frame_tick  <= 1'b0;
      sample_cnt  <= '0;
      cfg_err     <= 1'b0;
      resync_cnt  <= '0;
    end else begin
      ptp_sec_q   <= ptp_sec;
      ptp_ns_q    <= ptp_ns;
      ptp_step_q  <= ptp_step;
      sample_tick <= 1'b0;
      frame_tick  <= 1'b0;
      case (st)
        S_IDLE: begin
          if (!cfg_stop && cfg_arm) begin
            if (start_ok_c) begin
              tgt_sec <= cfg_start_sec;
              tgt_ns  <= cfg_start_ns;
              rem_acc <= '0;
              st      <= S_ARMED;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (cfg_stop) begin
            st <= S_IDLE;
          end else if (cfg_arm) begin
            // Re-latch; a rejected start keeps the previous one armed
            if (start_ok_c) begin
              tgt_sec <= cfg_start_sec;
              tgt_ns  <= cfg_start_ns;
              rem_acc <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end else if (ge_c) begin
            sample_tick        <= 1'b1;
            frame_tick         <= 1'b1;
            sample_cnt         <= '0;
            frame_idx          <= FIDX_W'((FRAME_SAMPLES > 1) ? 1 : 0);
            rem_acc            <= rem_nxt_c;
            {tgt_sec, tgt_ns}  <= adv_c;
            st                 <= S_RUN;
          end
        end
        S_RUN: begin
          if (cfg_stop) begin
            st <= S_IDLE;
          end else if (ptp_step_q) begin
            st <= S_RESYNC;
          end else if (ge_c && late_c) begin
            st <= S_RESYNC;
          end else if (ge_c) begin
            sample_tick        <= 1'b1;
            frame_tick         <= (frame_idx == '0);
            sample_cnt         <= sample_cnt + CNT_W'(1);
            frame_idx          <= frame_idx_nxt_c;
            rem_acc            <= rem_nxt_c;
            {tgt_sec, tgt_ns}  <= adv_c;
          end
        end
        S_RESYNC: begin
          if (cfg_stop) begin
            st <= S_IDLE;
          end else begin
            {tgt_sec, tgt_ns} <= resync_tgt_c;
            rem_acc           <= '0;
            frame_idx         <= '0;
            if (resync_cnt != {RES_W{1'b1}}) begin
              resync_cnt <= resync_cnt + RES_W'(1);
            end
            st <= S_RUN;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptp_media_clock_sched.sv
// Directed bench for ptp_media_clock_sched: start, long run, jump/step resync,
// stop, rejected arm and asynchronous reset.
module tb_ptp_media_clock_sched;

  localparam longint unsigned NS_S = 64'd1_000_000_000;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] ptp_sec;
  logic [31:0] ptp_ns;
  logic        ptp_step;
  logic [47:0] cfg_start_sec;
  logic [31:0] cfg_start_ns;
  logic        cfg_arm;
  logic        cfg_stop;
  logic        sample_tick;
  logic        frame_tick;
  logic [31:0] sample_cnt;
  logic [1:0]  state;
  logic        cfg_err;
  logic [15:0] resync_cnt;

  int checks = 0;
  int errors = 0;

  // Time driven now, registered at the last edge, and registered one edge earlier
  longint unsigned t_now, t_h1, t_h2;

  ptp_media_clock_sched dut (
    .clk           (clk),
    .rst           (rst),
    .ptp_sec       (ptp_sec),
    .ptp_ns        (ptp_ns),
    .ptp_step      (ptp_step),
    .cfg_start_sec (cfg_start_sec),
    .cfg_start_ns  (cfg_start_ns),
    .cfg_arm       (cfg_arm),
    .cfg_stop      (cfg_stop),
    .sample_tick   (sample_tick),
    .frame_tick    (frame_tick),
    .sample_cnt    (sample_cnt),
    .state         (state),
    .cfg_err       (cfg_err),
    .resync_cnt    (resync_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_t(input longint unsigned t);
    t_now   = t;
    ptp_sec = 48'(t / NS_S);
    ptp_ns  = 32'(t % NS_S);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    t_h2 = t_h1;
    t_h1 = t_now;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // No tick one ns before the target, a tick exactly at it
  task automatic probe(input longint unsigned tt, input logic [31:0] cnt, input logic fr, input string tag);
    set_t(tt - 1);
    clk1();
    clk1();
    chk({tag, " early"}, 64'(sample_tick), 64'd0);
    set_t(tt);
    clk1();
    clk1();
    chk({tag, " tick"}, 64'(sample_tick), 64'd1);
    chk({tag, " cnt"}, 64'(sample_cnt), 64'(cnt));
    chk({tag, " frame"}, 64'(frame_tick), 64'(fr));
  endtask

  initial begin
    longint unsigned tgt;
    longint unsigned jt;
    longint unsigned bt;
    longint unsigned st_t;
    int per [3];
    int nt;
    int nf;
    int extra;
    bit found;

    per[0] = 20833; per[1] = 20833; per[2] = 20834;
    rst = 1'b1; ptp_step = 1'b0; cfg_arm = 1'b0; cfg_stop = 1'b0;
    cfg_start_sec = '0; cfg_start_ns = '0;
    t_h1 = 0; t_h2 = 0;
    set_t(64'd9_999_999_000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst tick", 64'(sample_tick), 64'd0);
    chk("rst frame", 64'(frame_tick), 64'd0);
    chk("rst cnt", 64'(sample_cnt), 64'd0);
    chk("rst state", 64'(state), 64'd0);
    chk("rst cfg_err", 64'(cfg_err), 64'd0);
    chk("rst resync", 64'(resync_cnt), 64'd0);
    rst = 1'b0;

    // Arm at 10 s and walk PTP up in 20 ns steps
    cfg_start_sec = 48'd10; cfg_start_ns = 32'd0; cfg_arm = 1'b1;
    clk1();
    cfg_arm = 1'b0;
    chk("armed state", 64'(state), 64'd1);
    for (int i = 0; i < 200; i++) begin
      set_t(t_now + 20);
      clk1();
      if (sample_tick) break;
    end
    chk("first tick", 64'(sample_tick), 64'd1);
    chk("first tick time", t_h2, 64'd10_000_000_000);
    chk("first cnt", 64'(sample_cnt), 64'd0);
    chk("first frame", 64'(frame_tick), 64'd1);
    chk("run state", 64'(state), 64'd2);

    // Exact period pattern 20833, 20833, 20834
    tgt = 64'd10_000_000_000;
    for (int k = 1; k <= 6; k++) begin
      tgt = tgt + longint'(per[(k - 1) % 3]);
      probe(tgt, 32'(k), 1'b0, $sformatf("fine%0d", k));
    end

    // One second of ticks with coarse PTP steps
    nt = 7; nf = 1; found = 1'b0;
    set_t(64'd10_000_140_000);
    for (int i = 0; i < 60000; i++) begin
      set_t(t_now + 20000);
      clk1();
      if (sample_tick) begin
        if (t_h2 < 64'd11_000_000_000) begin
          nt++;
          if (frame_tick) nf++;
        end
        if (sample_cnt == 32'd48000) begin
          found = 1'b1;
          chk("tick 48000 time", t_h2, 64'd11_000_000_000);
          chk("tick 48000 frame", 64'(frame_tick), 64'd1);
          break;
        end
      end
    end
    chk("found tick 48000", 64'(found), 64'd1);
    chk("ticks in 1s", 64'(nt), 64'd48000);
    chk("frames in 1s", 64'(nf), 64'd1000);

    // Forward jump of 1 ms without ptp_step
    jt = 64'd11_001_000_000;
    set_t(jt);
    clk1();
    clk1();
    chk("jump no tick", 64'(sample_tick), 64'd0);
    chk("jump resync state", 64'(state), 64'd3);
    clk1();
    chk("jump back to run", 64'(state), 64'd2);
    chk("jump resync_cnt", 64'(resync_cnt), 64'd1);
    probe(jt + 20833, 32'd48001, 1'b1, "post-jump");

    // Backward step of 0.5 s flagged by ptp_step
    bt = jt + 20833 - 64'd500_000_000;
    set_t(bt);
    ptp_step = 1'b1;
    clk1();
    ptp_step = 1'b0;
    clk1();
    chk("step resync state", 64'(state), 64'd3);
    chk("step no tick", 64'(sample_tick), 64'd0);
    clk1();
    chk("step back to run", 64'(state), 64'd2);
    chk("step resync_cnt", 64'(resync_cnt), 64'd2);
    probe(bt + 20833, 32'd48002, 1'b1, "post-step");
    extra = 0;
    repeat (5) begin
      clk1();
      extra += int'(sample_tick);
    end
    chk("no catch-up burst", 64'(extra), 64'd0);

    // Stop and arm together: stop wins
    cfg_start_sec = '0; cfg_start_ns = 32'd5;
    cfg_stop = 1'b1; cfg_arm = 1'b1;
    clk1();
    cfg_stop = 1'b0; cfg_arm = 1'b0;
    chk("stop state", 64'(state), 64'd0);
    chk("stop no tick", 64'(sample_tick), 64'd0);
    extra = 0;
    repeat (20) begin
      set_t(t_now + 50000);
      clk1();
      extra += int'(sample_tick);
    end
    chk("idle no ticks", 64'(extra), 64'd0);

    // Rejected arm, then a valid one
    cfg_start_sec = 48'd11; cfg_start_ns = 32'd1_000_000_000; cfg_arm = 1'b1;
    clk1();
    cfg_arm = 1'b0;
    chk("bad arm cfg_err", 64'(cfg_err), 64'd1);
    chk("bad arm state", 64'(state), 64'd0);
    st_t = t_now + 64'd100_000;
    cfg_start_sec = 48'(st_t / NS_S); cfg_start_ns = 32'(st_t % NS_S); cfg_arm = 1'b1;
    clk1();
    cfg_arm = 1'b0;
    chk("rearm state", 64'(state), 64'd1);
    chk("cfg_err sticky", 64'(cfg_err), 64'd1);
    probe(st_t, 32'd0, 1'b1, "rearm");
    chk("rearm run", 64'(state), 64'd2);

    // Asynchronous reset while a tick is high
    #1;
    rst = 1'b1;
    #1;
    chk("async tick", 64'(sample_tick), 64'd0);
    chk("async frame", 64'(frame_tick), 64'd0);
    chk("async cnt", 64'(sample_cnt), 64'd0);
    chk("async state", 64'(state), 64'd0);
    chk("async cfg_err", 64'(cfg_err), 64'd0);
    chk("async resync", 64'(resync_cnt), 64'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
